// File: rtl/spram_test_runner.sv
// Host-side sequencer for a run/running/passed self-test fixture: start-up delay,
// RUNS timed passes, pass count and sticky fail flag, LED-level status outputs.
//
//   state   | meaning
//   STARTUP | hold-off after reset, o_run low
//   ARM     | o_run high, waiting for fixture to report running
//   BUSY    | o_run high, waiting for fixture to finish
//   SAMPLE  | one cycle: latch the fixture's passed result
//   GAP     | o_run low so the fixture can re-arm
//   DONE    | all passes finished, absorbing until reset
module spram_test_runner #(
  parameter int STARTUP = 64,
  parameter int RUNS    = 4,
  parameter int TIMEOUT = 1_048_576,
  parameter int GAP     = 16,
  parameter int BLINK   = 24
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  output logic                      o_run,
  input  logic                      i_running,
  input  logic                      i_passed,
  output logic                      o_led_r,
  output logic                      o_led_g,
  output logic                      o_led_b,
  output logic                      o_done,
  output logic                      o_fail,
  output logic [$clog2(RUNS+1)-1:0] o_pass_count
);

  localparam int PW      = $clog2(RUNS + 1);
  localparam int MAX_A   = (STARTUP > TIMEOUT) ? STARTUP : TIMEOUT;
  localparam int CNT_MAX = (MAX_A > GAP) ? MAX_A : GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] CNT_SAT    = CW'(CNT_MAX);
  localparam logic [CW-1:0] STARTUP_TC = CW'(STARTUP - 1);
  localparam logic [CW-1:0] TMO_TC     = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_TC     = CW'(GAP - 1);
  localparam logic [PW-1:0] RUNS_V     = PW'(RUNS);

  typedef enum logic [2:0] {
    S_STARTUP = 3'd0,
    S_ARM     = 3'd1,
    S_BUSY    = 3'd2,
    S_SAMPLE  = 3'd3,
    S_GAP     = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   passes_q, passes_d;
  logic [PW-1:0]   pass_cnt_q, pass_cnt_d;
  logic            fail_q, fail_d;
  logic            done_q, done_d;
  logic            led_r_q, led_r_d;
  logic            led_g_q, led_g_d;
  logic            led_b_q, led_b_d;
  logic [BLINK:0]  hb_q, hb_d;
  logic [1:0]      run_sync_q, pass_sync_q;
  logic            running_s, passed_s;
  logic            tmo_tc;
  logic            entering;

  assign running_s = run_sync_q[1];
  assign passed_s  = pass_sync_q[1];
  assign tmo_tc    = (cnt_q == TMO_TC);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_STARTUP;
      cnt_q       <= '0;
      passes_q    <= '0;
      pass_cnt_q  <= '0;
      fail_q      <= 1'b0;
      done_q      <= 1'b0;
      led_r_q     <= 1'b0;
      led_g_q     <= 1'b0;
      led_b_q     <= 1'b0;
      hb_q        <= '0;
      run_sync_q  <= '0;
      pass_sync_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      passes_q    <= passes_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_q      <= fail_d;
      done_q      <= done_d;
      led_r_q     <= led_r_d;
      led_g_q     <= led_g_d;
      led_b_q     <= led_b_d;
      hb_q        <= hb_d;
      run_sync_q  <= {run_sync_q[0], i_running};
      pass_sync_q <= {pass_sync_q[0], i_passed};
    end
  end

  // A fixture response wins over a timeout landing on the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_STARTUP: if (cnt_q == STARTUP_TC) state_d = S_ARM;
      S_ARM: begin
        if (running_s)   state_d = S_BUSY;
        else if (tmo_tc) state_d = S_GAP;
      end
      S_BUSY: begin
        if (!running_s)  state_d = S_SAMPLE;
        else if (tmo_tc) state_d = S_GAP;
      end
      S_SAMPLE: state_d = S_GAP;
      S_GAP: begin
        if (cnt_q == GAP_TC) state_d = (passes_q < RUNS_V) ? S_ARM : S_DONE;
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_STARTUP;
    endcase
  end

  always_comb begin
    entering = (state_d != state_q);

    cnt_d = cnt_q;
    if (entering)            cnt_d = '0;
    else if (cnt_q != CNT_SAT) cnt_d = cnt_q + CW'(1);

    passes_d = passes_q;
    if (entering && (state_d == S_GAP) && (passes_q != RUNS_V))
      passes_d = passes_q + PW'(1);

    pass_cnt_d = pass_cnt_q;
    if ((state_q == S_SAMPLE) && passed_s && (pass_cnt_q != RUNS_V))
      pass_cnt_d = pass_cnt_q + PW'(1);

    fail_d = fail_q;
    if ((state_q == S_SAMPLE) && !passed_s)
      fail_d = 1'b1;
    if (((state_q == S_ARM) || (state_q == S_BUSY)) && (state_d == S_GAP))
      fail_d = 1'b1;

    done_d  = done_q | (state_d == S_DONE);
    hb_d    = hb_q + (BLINK+1)'(1);
    led_r_d = fail_d;
    led_g_d = done_d & ~fail_d;
    led_b_d = (state_d != S_DONE) & hb_d[BLINK];
  end

  always_comb begin
    o_run = (state_q == S_ARM) || (state_q == S_BUSY) || (state_q == S_SAMPLE);
  end

  assign o_led_r      = led_r_q;
  assign o_led_g      = led_g_q;
  assign o_led_b      = led_b_q;
  assign o_done       = done_q;
  assign o_fail       = fail_q;
  assign o_pass_count = pass_cnt_q;

endmodule
